quad_decoder_counter: RTL and testbench

- Quadrature (A/B) incremental-encoder front end with a 4x up/down position counter.
- Works in the opposite direction to the team's binary counters. It recovers count-enable and direction from external two-phase signals instead of taking them as inputs.
- Sits between asynchronous encoder pins and the FPGA control logic. It provides position, step and direction indications, and wrap and error flags.

---
 rtl/quad_decoder_counter_if.sv | 27 ++
 rtl/quad_decoder_counter.sv | 114 +++++++++++
 tb/tb_quad_decoder_counter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_counter_if.sv
// Signal bundle between the quadrature decoder and its user: encoder pins,
// counter controls and the position/status outputs.
interface quad_decoder_counter_if #(
    parameter int WIDTH = 16
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             err_clr;
    logic [WIDTH-1:0] pos;
    logic             step;
    logic             dir;
    logic             wrap;
    logic             err;

    modport master (
        output a_in, b_in, en, load, load_data, err_clr,
        input  pos, step, dir, wrap, err
    );

    modport slave (
        input  a_in, b_in, en, load, load_data, err_clr,
        output pos, step, dir, wrap, err
    );
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature encoder front end: synchronizes and debounces phases A/B, decodes
// Gray-code transitions and drives a 4x up/down position counter.
module quad_decoder_counter #(
    parameter int WIDTH  = 16,
    parameter int FILTER = 2
) (
    input logic                   clk,
    input logic                   rst,
    quad_decoder_counter_if.slave bus
);

    localparam int CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    // Bit 1 carries phase A, bit 0 carries phase B throughout.
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       filt;
    logic [1:0]       prev;
    logic [CW-1:0]    cnt [0:1];
    logic             mv_up;
    logic             mv_dn;
    logic             illegal;
    logic [WIDTH-1:0] pos_r;
    logic             step_r;
    logic             dir_r;
    logic             wrap_r;
    logic             err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {bus.a_in, bus.b_in};
            s2 <= s1;
        end
    end

    // A new level is accepted only after it has differed from filt for
    // FILTER consecutive samples; any return to filt restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            prev <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        mv_up   = 1'b0;
        mv_dn   = 1'b0;
        illegal = 1'b0;
        case ({prev, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_up   = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: mv_dn   = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
            default: ;
        endcase
    end

    // Load wins over a coincident count; error tracking ignores en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r  <= '0;
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            step_r <= 1'b0;
            wrap_r <= 1'b0;
            if (bus.load) begin
                pos_r <= bus.load_data;
            end else if (bus.en && mv_up) begin
                pos_r  <= pos_r + WIDTH'(1);
                step_r <= 1'b1;
                dir_r  <= 1'b1;
                wrap_r <= (pos_r == '1);
            end else if (bus.en && mv_dn) begin
                pos_r  <= pos_r - WIDTH'(1);
                step_r <= 1'b1;
                dir_r  <= 1'b0;
                wrap_r <= (pos_r == '0);
            end
            if (illegal) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.pos  = pos_r;
    assign bus.step = step_r;
    assign bus.dir  = dir_r;
    assign bus.wrap = wrap_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Bench for quad_decoder_counter: directed encoder waveforms, a cycle-level
// reference model compared every cycle, plus hand-computed spot checks.
module tb_quad_decoder_counter;

    localparam int WIDTH  = 16;
    localparam int FILTER = 2;
    localparam int HMAX   = 4096;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;
    logic checking = 1'b0;

    quad_decoder_counter_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder_counter #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pin history indexed by edges since reset; a phase is
    // accepted once its last FILTER synchronized samples all disagree with it.
    logic [1:0]       hist [0:HMAX-1];
    int               edgeNo = 0;
    logic [1:0]       mFilt = 2'b00;
    logic [1:0]       mPrev = 2'b00;
    logic [WIDTH-1:0] mPos = '0;
    logic             mStep = 1'b0;
    logic             mDir = 1'b0;
    logic             mWrap = 1'b0;
    logic             mErr = 1'b0;

    function automatic int grayIdx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] seenAt(input int j);
        if (j < 1 || j >= HMAX) return 2'b00;
        return hist[j];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edgeNo = 0;
            mFilt = 2'b00; mPrev = 2'b00; mPos = '0;
            mStep = 1'b0; mDir = 1'b0; mWrap = 1'b0; mErr = 1'b0;
        end else begin
            int delta;
            edgeNo++;
            if (edgeNo < HMAX) hist[edgeNo] = {bus.a_in, bus.b_in};
            delta = (grayIdx(mFilt) - grayIdx(mPrev) + 4) % 4;
            mStep = 1'b0;
            mWrap = 1'b0;
            if (delta == 2) mErr = 1'b1;
            else if (bus.err_clr) mErr = 1'b0;
            if (bus.load) begin
                mPos = bus.load_data;
            end else if (bus.en && delta == 1) begin
                mWrap = (mPos == {WIDTH{1'b1}});
                mPos  = mPos + 1;
                mStep = 1'b1;
                mDir  = 1'b1;
            end else if (bus.en && delta == 3) begin
                mWrap = (mPos == '0);
                mPos  = mPos - 1;
                mStep = 1'b1;
                mDir  = 1'b0;
            end
            mPrev = mFilt;
            for (int b = 0; b < 2; b++) begin
                logic stable;
                stable = 1'b1;
                for (int j = edgeNo - FILTER - 1; j <= edgeNo - 2; j++) begin
                    logic [1:0] s;
                    s = seenAt(j);
                    if (s[b] == mFilt[b]) stable = 1'b0;
                end
                if (stable) mFilt[b] = ~mFilt[b];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_pos",  32'(bus.pos),  32'(mPos));
            checkOutput("model_step", 32'(bus.step), 32'(mStep));
            checkOutput("model_dir",  32'(bus.dir),  32'(mDir));
            checkOutput("model_wrap", 32'(bus.wrap), 32'(mWrap));
            checkOutput("model_err",  32'(bus.err),  32'(mErr));
        end
    end

    task automatic applyStimulus(input logic a, input logic b, input int cycles);
        bus.a_in = a;
        bus.b_in = b;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.a_in = 1'b0; bus.b_in = 1'b0; bus.en = 1'b1; bus.load = 1'b0;
        bus.load_data = '0; bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pos", 32'(bus.pos), 32'h0);
        checkOutput("reset_err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        // Forward: first edge must land exactly FILTER+3 edges after the pin change
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("lat_pos_early",  32'(bus.pos),  32'h0);
        checkOutput("lat_step_early", 32'(bus.step), 32'h0);
        @(negedge clk);
        checkOutput("lat_pos",  32'(bus.pos),  32'h1);
        checkOutput("lat_step", 32'(bus.step), 32'h1);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("fwd_pos", 32'(bus.pos), 32'h4);
        checkOutput("fwd_dir", 32'(bus.dir), 32'h1);
        checkOutput("fwd_err", 32'(bus.err), 32'h0);

        // Reverse from zero
        bus.load = 1'b1; bus.load_data = '0;
        @(negedge clk);
        bus.load = 1'b0;
        applyStimulus(1'b1, 1'b0, 4);
        @(negedge clk);
        checkOutput("rev_wrap_first", 32'(bus.wrap), 32'h1);
        repeat (5) @(negedge clk);
        checkOutput("rev_pos1", 32'(bus.pos), 32'hFFFF);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("rev_pos2", 32'(bus.pos), 32'hFFFE);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("rev_pos3", 32'(bus.pos), 32'hFFFD);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("rev_pos4", 32'(bus.pos), 32'hFFFC);
        checkOutput("rev_dir",  32'(bus.dir), 32'h0);

        // Glitches on A around base 01
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("glitch1_pos", 32'(bus.pos), 32'hFFFD);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("glitch2_pos", 32'(bus.pos), 32'hFFFD);
        checkOutput("glitch2_dir", 32'(bus.dir), 32'h0);
        checkOutput("glitch_err",  32'(bus.err), 32'h0);

        // Illegal transitions and error clearing
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("ill_err", 32'(bus.err), 32'h1);
        checkOutput("ill_pos", 32'(bus.pos), 32'hFFFC);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checkOutput("clr_err", 32'(bus.err), 32'h0);
        applyStimulus(1'b0, 1'b0, 4);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checkOutput("clr_vs_ill_err", 32'(bus.err), 32'h1);
        repeat (5) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checkOutput("clr2_err", 32'(bus.err), 32'h0);

        // Load coincident with an up transition
        applyStimulus(1'b0, 1'b1, 4);
        bus.load = 1'b1; bus.load_data = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        checkOutput("load_pos",  32'(bus.pos),  32'h1234);
        checkOutput("load_step", 32'(bus.step), 32'h0);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("after_load_pos", 32'(bus.pos), 32'h1235);

        // Counting disabled across three transitions
        bus.en = 1'b0;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("en0_pos", 32'(bus.pos), 32'h1235);
        bus.en = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reen_pos", 32'(bus.pos), 32'h1235);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("en1_pos", 32'(bus.pos), 32'h1236);

        // Asynchronous reset mid-transition, pins held at 01 through release
        applyStimulus(1'b1, 1'b0, 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_pos", 32'(bus.pos), 32'h0);
        checkOutput("arst_dir", 32'(bus.dir), 32'h0);
        bus.a_in = 1'b0; bus.b_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_pos_early", 32'(bus.pos), 32'h0);
        @(negedge clk);
        checkOutput("post_rst_pos",  32'(bus.pos),  32'h1);
        checkOutput("post_rst_step", 32'(bus.step), 32'h1);
        repeat (5) @(negedge clk);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
